// File: rtl/hci_bank_arbiter_if.sv
// Requester-side and bank-side signal bundle of one TCDM bank arbiter.
// The slave modport is the arbiter's view; master is the surrounding interconnect/bank.
interface hci_bank_arbiter_if #(
  parameter int unsigned N  = 6,
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 32
);
  logic [N-1:0]              in_req_i;
  logic [N-1:0][AW-1:0]      in_add_i;
  logic [N-1:0]              in_wen_i;
  logic [N-1:0][DW-1:0]      in_data_i;
  logic [N-1:0][DW/8-1:0]    in_be_i;
  logic [N-1:0]              in_gnt_o;
  logic [N-1:0]              in_r_valid_o;
  logic [DW-1:0]             in_r_data_o;

  logic                      mem_req_o;
  logic [AW-1:0]             mem_add_o;
  logic                      mem_wen_o;
  logic [DW-1:0]             mem_data_o;
  logic [DW/8-1:0]           mem_be_o;
  logic                      mem_gnt_i;
  logic [DW-1:0]             mem_r_data_i;

  modport slave (
    input  in_req_i, in_add_i, in_wen_i, in_data_i, in_be_i,
    output in_gnt_o, in_r_valid_o, in_r_data_o,
    output mem_req_o, mem_add_o, mem_wen_o, mem_data_o, mem_be_o,
    input  mem_gnt_i, mem_r_data_i
  );

  modport master (
    output in_req_i, in_add_i, in_wen_i, in_data_i, in_be_i,
    input  in_gnt_o, in_r_valid_o, in_r_data_o,
    input  mem_req_o, mem_add_o, mem_wen_o, mem_data_o, mem_be_o,
    output mem_gnt_i, mem_r_data_i
  );
endinterface

// File: rtl/hci_bank_arbiter.sv
// Per-bank arbiter sharing one SRAM port between CH0 (core) and CH1 (accelerator) requesters,
// with runtime-selectable flat round-robin or CH1-priority with a CH0 starvation guard.
module hci_bank_arbiter #(
  parameter int unsigned N_CH0     = 4,
  parameter int unsigned N_CH1     = 2,
  parameter int unsigned AW        = 12,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_STALL = 8,
  parameter int unsigned N         = N_CH0 + N_CH1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              arb_policy_i,
  hci_bank_arbiter_if.slave bus
);

  localparam int unsigned IW  = (N > 1)     ? $clog2(N)     : 1;
  localparam int unsigned P0W = (N_CH0 > 1) ? $clog2(N_CH0) : 1;
  localparam int unsigned P1W = (N_CH1 > 1) ? $clog2(N_CH1) : 1;
  localparam int unsigned SW  = $clog2(MAX_STALL + 1);

  logic [IW-1:0]  rr_q, rr_d;
  logic [P0W-1:0] ptr0_q, ptr0_d;
  logic [P1W-1:0] ptr1_q, ptr1_d;
  logic [SW-1:0]  stall_q, stall_d;
  logic           resp_valid_q, resp_valid_d;
  logic [IW-1:0]  resp_idx_q, resp_idx_d;

  logic [IW-1:0]  win_rr, win0, win1, win;
  logic [P0W-1:0] win0_rel;
  logic [P1W-1:0] win1_rel;
  logic           hit_rr, any0, any1, any_req, accept, sel1, acc_ch0;

  // Round-robin searches: flat over all N, and within each group from its own pointer
  always_comb begin : rr_search
    int unsigned j;
    j        = 0;
    win_rr   = '0;
    win0_rel = '0;
    win1_rel = '0;
    hit_rr   = 1'b0;
    any0     = 1'b0;
    any1     = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(rr_q) + k;
      if (j >= N) j = j - N;
      if (!hit_rr && bus.in_req_i[IW'(j)]) begin
        hit_rr = 1'b1;
        win_rr = IW'(j);
      end
    end
    for (int unsigned k = 0; k < N_CH0; k++) begin
      j = 32'(ptr0_q) + k;
      if (j >= N_CH0) j = j - N_CH0;
      if (!any0 && bus.in_req_i[IW'(j)]) begin
        any0     = 1'b1;
        win0_rel = P0W'(j);
      end
    end
    for (int unsigned k = 0; k < N_CH1; k++) begin
      j = 32'(ptr1_q) + k;
      if (j >= N_CH1) j = j - N_CH1;
      if (!any1 && bus.in_req_i[IW'(N_CH0 + j)]) begin
        any1     = 1'b1;
        win1_rel = P1W'(j);
      end
    end
  end

  // Winner selection; a saturated stall counter overrides CH1 priority
  always_comb begin : winner_sel
    win0    = IW'(32'(win0_rel));
    win1    = IW'(N_CH0 + 32'(win1_rel));
    any_req = |bus.in_req_i;
    accept  = any_req & bus.mem_gnt_i;
    sel1    = arb_policy_i & any1 & ~(any0 & (stall_q == SW'(MAX_STALL)));
    win     = arb_policy_i ? (sel1 ? win1 : win0) : win_rr;
    acc_ch0 = accept & arb_policy_i & ~sel1;
  end

  // Bank-side mux, grants and response fan-out
  always_comb begin : bank_mux
    bus.mem_req_o    = any_req;
    bus.mem_add_o    = '0;
    bus.mem_wen_o    = 1'b1;
    bus.mem_data_o   = '0;
    bus.mem_be_o     = '0;
    bus.in_gnt_o     = '0;
    bus.in_r_valid_o = '0;
    bus.in_r_data_o  = bus.mem_r_data_i;
    if (any_req) begin
      bus.mem_add_o  = bus.in_add_i[win];
      bus.mem_wen_o  = bus.in_wen_i[win];
      bus.mem_data_o = bus.in_data_i[win];
      bus.mem_be_o   = bus.in_be_i[win];
    end
    if (accept) bus.in_gnt_o[win] = 1'b1;
    if (resp_valid_q) bus.in_r_valid_o[resp_idx_q] = 1'b1;
  end

  // Next-state: pointers and stall counter only move on a granted bank cycle
  always_comb begin : next_state
    rr_d         = rr_q;
    ptr0_d       = ptr0_q;
    ptr1_d       = ptr1_q;
    stall_d      = stall_q;
    resp_valid_d = accept;
    resp_idx_d   = accept ? win : resp_idx_q;

    if (accept) begin
      if (!arb_policy_i) begin
        rr_d = (win_rr == IW'(N - 1)) ? '0 : win_rr + IW'(1);
      end else if (sel1) begin
        ptr1_d = (win1_rel == P1W'(N_CH1 - 1)) ? '0 : win1_rel + P1W'(1);
      end else begin
        ptr0_d = (win0_rel == P0W'(N_CH0 - 1)) ? '0 : win0_rel + P0W'(1);
      end
    end

    if (!arb_policy_i) begin
      stall_d = '0;
    end else if (bus.mem_gnt_i) begin
      if (!any0 || acc_ch0) stall_d = '0;
      else if (stall_q != SW'(MAX_STALL)) stall_d = stall_q + SW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : state_reg
    if (!rst_ni) begin
      rr_q         <= '0;
      ptr0_q       <= '0;
      ptr1_q       <= '0;
      stall_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_idx_q   <= '0;
    end else begin
      rr_q         <= rr_d;
      ptr0_q       <= ptr0_d;
      ptr1_q       <= ptr1_d;
      stall_q      <= stall_d;
      resp_valid_q <= resp_valid_d;
      resp_idx_q   <= resp_idx_d;
    end
  end

endmodule

// File: tb/tb_hci_bank_arbiter.sv
// Scoreboard bench for hci_bank_arbiter: expected grants queued per driven cycle,
// popped and compared (grant, address mux, next-cycle r_valid) on the falling edge.
module tb_hci_bank_arbiter;

  localparam int unsigned N  = 6;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic arb_policy_i;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_q[$];
  logic [N-1:0] exp_rv = '0;

  hci_bank_arbiter_if #(.N(N), .AW(AW), .DW(DW)) bus ();

  hci_bank_arbiter #(
    .N_CH0(4), .N_CH1(2), .AW(AW), .DW(DW), .MAX_STALL(8)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .arb_policy_i (arb_policy_i),
    .bus          (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [N-1:0] onehot(input int e);
    logic [N-1:0] v;
    v = '0;
    if (e >= 0) v[e] = 1'b1;
    return v;
  endfunction

  // Queue the expected winner for the current cycle (-1 = no grant) and advance one cycle
  task automatic cyc(input int exp_win);
    exp_q.push_back(exp_win);
    @(posedge clk_i);
    #1;
  endtask

  always @(negedge clk_i) begin : monitor
    int e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (!rst_ni) exp_rv = '0;
      chk("r_valid", 64'(bus.in_r_valid_o), 64'(exp_rv));
      chk("gnt", 64'(bus.in_gnt_o), 64'(onehot(e)));
      if (e >= 0) chk("mem_add", 64'(bus.mem_add_o), 64'(bus.in_add_i[e]));
      exp_rv = rst_ni ? onehot(e) : '0;
    end
  end

  initial begin
    int seq1[8]  = '{0, 1, 2, 3, 4, 5, 0, 1};
    int seq3[11] = '{4, 5, 4, 5, 4, 5, 4, 5, 0, 4, 5};

    rst_ni           = 1'b0;
    arb_policy_i     = 1'b0;
    bus.in_req_i     = '0;
    bus.in_wen_i     = '1;
    bus.mem_gnt_i    = 1'b1;
    bus.mem_r_data_i = 32'hCAFE_0000;
    for (int i = 0; i < int'(N); i++) begin
      bus.in_add_i[i]  = AW'(12'h100 + i);
      bus.in_data_i[i] = DW'(32'hA000_0000 + i);
      bus.in_be_i[i]   = 4'hF;
    end

    @(posedge clk_i);
    #1;
    chk("rst_r_valid", 64'(bus.in_r_valid_o), 64'(0));
    chk("rst_mem_req", 64'(bus.mem_req_o), 64'(0));
    chk("rst_mem_wen", 64'(bus.mem_wen_o), 64'(1));
    chk("rst_mem_add", 64'(bus.mem_add_o), 64'(0));
    rst_ni = 1'b1;
    cyc(-1);

    // Flat round-robin, everyone requesting
    bus.in_req_i = 6'b111111;
    foreach (seq1[i]) cyc(seq1[i]);

    // Bring rr_ptr to 3, then only 2 and 5 requesting: 5, 2, 5
    bus.in_req_i = 6'b000100;
    cyc(2);
    bus.in_req_i = 6'b100100;
    cyc(5);
    cyc(2);
    cyc(5);
    bus.in_req_i = '0;
    cyc(-1);

    // CH1 priority with starvation guard after 8 stalled cycles
    arb_policy_i = 1'b1;
    bus.in_req_i = 6'b110001;
    foreach (seq3[i]) cyc(seq3[i]);
    bus.in_req_i = '0;
    cyc(-1);

    // Bank stall holds everything, then grant and read-data pass-through
    arb_policy_i  = 1'b0;
    bus.in_req_i  = 6'b000010;
    bus.mem_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_mem_req", 64'(bus.mem_req_o), 64'(1));
      cyc(-1);
    end
    bus.mem_gnt_i = 1'b1;
    cyc(1);
    bus.in_req_i     = '0;
    bus.mem_r_data_i = 32'hDEADBEEF;
    #1;
    chk("r_data", 64'(bus.in_r_data_o), 64'(32'hDEADBEEF));
    chk("r_valid1", 64'(bus.in_r_valid_o[1]), 64'(1));
    cyc(-1);

    // Write from requester 3 reaches the bank unmodified
    bus.in_req_i     = 6'b001000;
    bus.in_wen_i[3]  = 1'b0;
    bus.in_be_i[3]   = 4'b0101;
    bus.in_data_i[3] = 32'h12345678;
    bus.in_add_i[3]  = 12'h0A5;
    #1;
    chk("wr_add", 64'(bus.mem_add_o), 64'(12'h0A5));
    chk("wr_wen", 64'(bus.mem_wen_o), 64'(0));
    chk("wr_be", 64'(bus.mem_be_o), 64'(4'b0101));
    chk("wr_data", 64'(bus.mem_data_o), 64'(32'h12345678));
    cyc(3);
    bus.in_req_i = '0;
    cyc(-1);

    // Reset right after a grant drops its response; pointers restart at 0
    bus.in_req_i = 6'b111111;
    cyc(4);
    rst_ni       = 1'b0;
    bus.in_req_i = '0;
    cyc(-1);
    rst_ni       = 1'b1;
    bus.in_req_i = 6'b111111;
    cyc(0);
    cyc(1);

    // Policy switch acts in the same cycle and keeps rr_ptr
    arb_policy_i = 1'b1;
    bus.in_req_i = 6'b100010;
    cyc(5);
    arb_policy_i = 1'b0;
    cyc(5);
    bus.in_req_i = '0;
    cyc(-1);
    cyc(-1);

    chk("sb_drain", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hci_bank_arbiter.md
Name: hci_bank_arbiter

Overview:
- Per-bank arbiter that shares one TCDM memory bank port between N_CH0 core-side and N_CH1 accelerator-side requesters.
- Sits between the log-interconnect routing stage and a single SRAM bank, one instance per bank.
- Selects one requester per cycle, forwards its transaction to the bank, and returns the response to the winner one cycle later.
- Arbitration policy is selectable at runtime; a starvation guard bounds the stall of CH0 requesters under accelerator priority.

Parameters:
- N_CH0, 4, number of CH0 (core) requesters, indices 0..N_CH0-1; must be >=1.
- N_CH1, 2, number of CH1 (accelerator) requesters, indices N_CH0..N-1; must be >=1.
- AW, 12, bank word-address width.
- DW, 32, data width; BE width is DW/8.
- MAX_STALL, 8, CH0 stall cycles tolerated under policy 1 before forced CH0 service; must be >=1.
- N, N_CH0+N_CH1, derived total requester count; not to be overridden.

Ports:
- clk_i, in, 1, clock.
- rst_ni, in, 1, asynchronous active-low reset.
- arb_policy_i, in, 1: 0 = flat round-robin; 1 = CH1 priority with starvation guard.
- in_req_i, in, N, per-requester request.
- in_add_i, in, N x AW, word address.
- in_wen_i, in, N, 1 = read, 0 = write.
- in_data_i, in, N x DW, write data.
- in_be_i, in, N x DW/8, byte enables.
- in_gnt_o, out, N, grant.
- in_r_valid_o, out, N, response valid.
- in_r_data_o, out, DW, read data broadcast to all requesters.
- mem_req_o, out, 1, bank request.
- mem_add_o, out, AW, bank address.
- mem_wen_o, out, 1, bank wen.
- mem_data_o, out, DW, bank write data.
- mem_be_o, out, DW/8, bank byte enables.
- mem_gnt_i, in, 1, bank grant.
- mem_r_data_i, in, DW, bank read data, valid one cycle after handshake.

Behaviour:
- Handshake:
  - An accepted transfer occurs in a cycle where mem_req_o & mem_gnt_i.
  - in_gnt_o[w] = (winner==w) & mem_req_o & mem_gnt_i; all other grant bits are 0.
  - Requesters hold req/add/wen/data/be stable until granted.
- Datapath selection:
  - Combinational path; mem_req_o = |in_req_i.
  - mem_add/wen/data/be are muxed from the winner.
  - When no request is present, they are 0 (wen = 1).
- Policy 0:
  - A single rr_ptr covers all N requesters.
  - Winner = first requesting index at or after rr_ptr, wrapping modulo N.
  - On acceptance, rr_ptr <= (winner+1) mod N; wrap from N-1 to 0.
- Policy 1:
  - Separate pointers: ptr0 over CH0, ptr1 over CH1; each is round-robin within its group with the same wrap rule inside the group.
  - Default: the CH1 group wins whenever any CH1 req is high; otherwise CH0 wins.
  - stall_cnt (width clog2(MAX_STALL+1)):
    - increments, saturating at MAX_STALL, each cycle any CH0 req is high and no CH0 index is accepted;
    - clears on CH0 acceptance or when no CH0 req is pending.
  - When stall_cnt == MAX_STALL, CH0 group wins regardless of CH1.
  - Only the pointer of the group that wins an accepted transfer advances.
- Pointers and stall_cnt hold when mem_gnt_i = 0 (the winner does not change while the bank stalls).
- Policy switching:
  - Takes effect combinationally the same cycle.
  - rr_ptr, ptr0, ptr1 retain their values across switches.
  - stall_cnt clears while policy = 0.
- Response:
  - On acceptance, register resp_valid <= 1 and resp_idx <= winner; otherwise resp_valid <= 0.
  - in_r_valid_o[resp_idx] = resp_valid, one cycle after grant, for both reads and writes.
  - in_r_data_o = mem_r_data_i passed through combinationally in the response cycle.
  - Back-to-back grants yield back-to-back responses; throughput is 1 transaction/cycle.
- Reset (asynchronous, rst_ni low):
  - rr_ptr, ptr0, ptr1 = 0; stall_cnt = 0; resp_valid = 0; resp_idx = 0.
  - Hence in_r_valid_o = 0.
  - in_gnt_o and mem_* follow inputs combinationally (0 when no req).
  - Reset asserted mid-transaction drops any pending response; no r_valid after reset release for pre-reset grants.
- Simultaneous events: a requester granted in cycle t may re-request in t+1 and receive its response in t+1 alongside a new grant.

Test Plan:
- Policy 0, N=6, all req high, mem_gnt_i=1 for 8 cycles -> grants in order 0,1,2,3,4,5,0,1; r_valid follows each grant by exactly 1 cycle.
- Policy 0, only req[2] and req[5] high, rr_ptr=3 -> grant 5, then 2, then 5 (wrap N-1 to 0 path exercised).
- Policy 1, req[4], req[5] and req[0] continuously high, MAX_STALL=8 -> CH1 alternates 4,5 for 8 cycles, 9th grant to 0, stall_cnt back to 0, then CH1 resumes.
- mem_gnt_i=0 for 3 cycles with req[1] high -> in_gnt_o=0 and pointers frozen; mem_gnt_i=1 -> grant 1, in_r_valid_o[1] next cycle with in_r_data_o = mem_r_data_i (e.g. 32'hDEADBEEF).
- Write from req[3] (wen=0, be=4'b0101, data=32'h12345678, add=12'h0A5) -> mem_* carry exactly these values the same cycle; in_r_valid_o[3] next cycle.
- Grant accepted at cycle t, rst_ni low during t+1 -> no in_r_valid_o; after release, first grant with all req high goes to index 0.
